// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin two-port arbiter and three-state access sequencer
//            in front of the 64-bit word-addressed data memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int MEM_SIZE = 256,
    parameter int ROM_SIZE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [63:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [63:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [63:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [63:0] p1_rdata,
    output logic        p1_err,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wr_data,
    output logic        mem_wr_enable,
    output logic        mem_rd_enable,
    input  logic [63:0] mem_rd_data
);

    localparam logic [31:0] C_MEM_SIZE = 32'(MEM_SIZE);
    localparam logic [31:0] C_ROM_SIZE = 32'(ROM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state_q, w_state_d;
    logic        r_owner_q, w_owner_d;
    logic        r_last_q,  w_last_d;
    logic        r_we_q,    w_we_d;
    logic [31:0] r_addr_q,  w_addr_d;
    logic [63:0] r_wdata_q, w_wdata_d;
    logic        r_err_q,   w_err_d;
    logic [63:0] r_rdata_q, w_rdata_d;

    logic        w_winner;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;

    // On a tie the port that did not win last time takes the slot.
    assign w_winner   = (p0_req && p1_req) ? ~r_last_q : p1_req;
    assign w_sel_we   = w_winner ? p1_we   : p0_we;
    assign w_sel_addr = w_winner ? p1_addr : p0_addr;

    always_comb begin
        w_state_d = r_state_q;
        w_owner_d = r_owner_q;
        w_last_d  = r_last_q;
        w_we_d    = r_we_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_err_d   = r_err_q;
        w_rdata_d = r_rdata_q;
        case (r_state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    w_owner_d = w_winner;
                    w_last_d  = w_winner;
                    w_we_d    = w_sel_we;
                    w_addr_d  = w_sel_addr;
                    w_wdata_d = w_winner ? p1_wdata : p0_wdata;
                    w_err_d   = (w_sel_addr >= C_MEM_SIZE) ||
                                (w_sel_we && (w_sel_addr < C_ROM_SIZE));
                    w_state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!r_we_q && !r_err_q) begin
                    w_rdata_d = mem_rd_data;
                end
                w_state_d = S_RESP;
            end
            S_RESP:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_owner_q <= 1'b0;
            r_last_q  <= 1'b1;
            r_we_q    <= 1'b0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_err_q   <= 1'b0;
            r_rdata_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_owner_q <= w_owner_d;
            r_last_q  <= w_last_d;
            r_we_q    <= w_we_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_err_q   <= w_err_d;
            r_rdata_q <= w_rdata_d;
        end
    end

    assign mem_addr    = r_addr_q;
    assign mem_wr_data = r_wdata_q;

    // Handshake outputs are masked by rst so an interrupted access has no effect.
    always_comb begin
        p0_gnt        = 1'b0;
        p1_gnt        = 1'b0;
        p0_rvalid     = 1'b0;
        p1_rvalid     = 1'b0;
        p0_err        = 1'b0;
        p1_err        = 1'b0;
        p0_rdata      = '0;
        p1_rdata      = '0;
        mem_wr_enable = 1'b0;
        mem_rd_enable = 1'b0;
        if (!rst) begin
            if (r_state_q == S_ACCESS) begin
                p0_gnt        = ~r_owner_q;
                p1_gnt        = r_owner_q;
                mem_wr_enable = r_we_q && !r_err_q;
                mem_rd_enable = !r_we_q && !r_err_q;
            end
            if (r_state_q == S_RESP) begin
                if (r_owner_q) begin
                    p1_rvalid = 1'b1;
                    p1_err    = r_err_q;
                    p1_rdata  = (!r_we_q && !r_err_q) ? r_rdata_q : 64'd0;
                end else begin
                    p0_rvalid = 1'b1;
                    p0_err    = r_err_q;
                    p0_rdata  = (!r_we_q && !r_err_q) ? r_rdata_q : 64'd0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p1_addr;
    logic [63:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [63:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr;
    logic [63:0] mem_wr_data, mem_rd_data;
    logic        mem_wr_enable, mem_rd_enable;

    logic        init_mem;
    logic [63:0] mem   [256];
    logic [63:0] m_mem [256];
    logic        m_last;
    int          n_checks;
    int          n_fail;

    dmem_arbiter #(.MEM_SIZE(256), .ROM_SIZE(2)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_enable(mem_wr_enable), .mem_rd_enable(mem_rd_enable),
        .mem_rd_data(mem_rd_data)
    );

    function automatic logic [63:0] fill(int i);
        if (i == 5) return 64'hDEAD;
        return {32'hC0DE0000 | 32'(i), 32'(i * 7)};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= fill(i);
        end else if (mem_wr_enable) begin
            mem[mem_addr[7:0]] <= mem_wr_data;
        end
    end
    assign mem_rd_data = mem[mem_addr[7:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " gnt"},    {62'd0, p1_gnt, p0_gnt}, 64'd0);
        chk({tag, " rvalid"}, {62'd0, p1_rvalid, p0_rvalid}, 64'd0);
        chk({tag, " err"},    {62'd0, p1_err, p0_err}, 64'd0);
        chk({tag, " rdata0"}, p0_rdata, 64'd0);
        chk({tag, " rdata1"}, p1_rdata, 64'd0);
        chk({tag, " mem_en"}, {62'd0, mem_wr_enable, mem_rd_enable}, 64'd0);
        chk({tag, " mem_addr"}, {32'd0, mem_addr}, 64'd0);
        chk({tag, " mem_wdata"}, mem_wr_data, 64'd0);
    endtask

    // One complete access, started at a falling edge while the arbiter idles.
    task automatic step(input logic [1:0] mask,
                        input logic we0, input logic [31:0] a0, input logic [63:0] d0,
                        input logic we1, input logic [31:0] a1, input logic [63:0] d1);
        logic        win, we, err;
        logic [31:0] a;
        logic [63:0] d, exp_rd;
        p0_req = mask[0]; p0_we = we0; p0_addr = a0; p0_wdata = d0;
        p1_req = mask[1]; p1_we = we1; p1_addr = a1; p1_wdata = d1;
        win    = (mask == 2'b11) ? !m_last : mask[1];
        m_last = win;
        we     = win ? we1 : we0;
        a      = win ? a1 : a0;
        d      = win ? d1 : d0;
        err    = (a >= 32'd256) || (we && a < 32'd2);
        exp_rd = (!we && !err) ? m_mem[a[7:0]] : 64'd0;

        @(negedge clk);
        chk("gnt0", {63'd0, p0_gnt}, {63'd0, !win});
        chk("gnt1", {63'd0, p1_gnt}, {63'd0, win});
        chk("wr_en", {63'd0, mem_wr_enable}, {63'd0, we && !err});
        chk("rd_en", {63'd0, mem_rd_enable}, {63'd0, !we && !err});
        if (!err) chk("mem_addr", {32'd0, mem_addr}, {32'd0, a});
        if (!err && we) chk("mem_wdata", mem_wr_data, d);
        p0_req = 1'b0;
        p1_req = 1'b0;

        @(negedge clk);
        chk("rvalid0", {63'd0, p0_rvalid}, {63'd0, !win});
        chk("rvalid1", {63'd0, p1_rvalid}, {63'd0, win});
        chk("err_owner", {63'd0, win ? p1_err : p0_err}, {63'd0, err});
        chk("rdata_owner", win ? p1_rdata : p0_rdata, exp_rd);
        chk("other_quiet", {win ? p0_rdata : p1_rdata} | {63'd0, win ? p0_err : p1_err}, 64'd0);
        chk("resp_idle", {60'd0, p0_gnt, p1_gnt, mem_wr_enable, mem_rd_enable}, 64'd0);
        if (we && !err) m_mem[a[7:0]] = d;

        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ra [2];
        n_checks = 0;
        n_fail   = 0;
        m_last   = 1'b1;
        for (int i = 0; i < 256; i++) m_mem[i] = fill(i);
        rst = 1'b1; init_mem = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0; init_mem = 1'b0;

        step(2'b01, 1'b0, 32'd5, 64'd0, 1'b0, 32'd0, 64'd0);
        step(2'b10, 1'b0, 32'd0, 64'd0, 1'b1, 32'd10, 64'h1234);
        step(2'b10, 1'b0, 32'd0, 64'd0, 1'b0, 32'd10, 64'd0);
        chk("mem10", mem[10], 64'h1234);
        for (int k = 0; k < 6; k++)
            step(2'b11, 1'b0, 32'd5, 64'd0, 1'b0, 32'd10, 64'd0);
        step(2'b01, 1'b1, 32'd1, 64'hFF, 1'b0, 32'd0, 64'd0);
        step(2'b01, 1'b0, 32'd1, 64'd0, 1'b0, 32'd0, 64'd0);
        step(2'b10, 1'b0, 32'd0, 64'd0, 1'b0, 32'd256, 64'd0);
        step(2'b10, 1'b0, 32'd0, 64'd0, 1'b0, 32'hFFFF_FFFF, 64'd0);
        step(2'b01, 1'b1, 32'd255, 64'h5555, 1'b0, 32'd0, 64'd0);
        step(2'b10, 1'b0, 32'd0, 64'd0, 1'b0, 32'd255, 64'd0);

        // Reset lands on the ACCESS cycle of a p0 write to word 20.
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'd20; p0_wdata = 64'hBAD0BAD0;
        @(negedge clk);
        p0_req = 1'b0;
        rst    = 1'b1;
        #1;
        chk("rst_access_wr_en", {63'd0, mem_wr_enable}, 64'd0);
        chk("rst_access_gnt", {63'd0, p0_gnt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("after_rst");
        chk("mem20_kept", mem[20], m_mem[20]);
        @(negedge clk);
        chk("no_late_rvalid", {62'd0, p1_rvalid, p0_rvalid}, 64'd0);
        m_last = 1'b1;
        step(2'b11, 1'b0, 32'd20, 64'd0, 1'b0, 32'd3, 64'd0);

        for (int k = 0; k < 80; k++) begin
            logic [1:0] mask;
            mask = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                case ($urandom_range(0, 9))
                    0:       ra[p] = $urandom;
                    1:       ra[p] = 32'd256 + 32'($urandom_range(0, 3));
                    2:       ra[p] = 32'($urandom_range(0, 1));
                    3:       ra[p] = 32'd255;
                    default: ra[p] = 32'($urandom_range(2, 40));
                endcase
            end
            step(mask, 1'($urandom_range(0, 1)), ra[0], {$urandom, $urandom},
                       1'($urandom_range(0, 1)), ra[1], {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the 64-bit word-addressed data memory. Shares the single memory port between the pipeline MEM stage (port 0) and the debug/loader port (port 1) with round-robin arbitration. Each access runs as a fixed three-state sequence (capture, access, respond). Out-of-range addresses and writes into the read-only low words are rejected with an error response, and no memory cycle is issued for them.

## Interface
- `mem_size`, 256: memory depth in 64-bit words; valid word addresses are `0..mem_size-1`.
- `rom_size`, 2: words `0..rom_size-1` are read-only.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset is synchronous and active-high; it returns the block to IDLE and clears every output.
- `p0_req`, `p1_req` in 1: access request; held high with stable command until the matching `gnt`.
- `p0_we`, `p1_we` in 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` in 32: word address (not byte address).
- `p0_wdata`, `p1_wdata` in 64: write data.
- `p0_gnt`, `p1_gnt` out 1: one-cycle pulse meaning the command has been captured; the requester may drop or change `req` after this edge.
- `p0_rvalid`, `p1_rvalid` out 1: one-cycle response pulse, for both reads and writes.
- `p0_rdata`, `p1_rdata` out 64: read data, valid with `rvalid`; 0 for writes and errors.
- `p0_err`, `p1_err` out 1: valid with `rvalid`; flags an out-of-range address or a write to the ROM region.
- `mem_addr` out 32: word address to memory.
- `mem_wr_data` out 64: write data to memory.
- `mem_wr_enable` out 1: memory write enable.
- `mem_rd_enable` out 1: memory read enable.
- `mem_rd_data` in 64: combinational read data from memory.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - With no `req`: stay in IDLE.
  - With any `req`: pick a winner, latch its `we`, `addr` and `wdata` plus the owner id, compute the error flag, then go to ACCESS.
- **Arbitration**
  - A single requester wins.
  - If both request, the port that did not win the last granted access wins.
  - The last-winner pointer resets to port 1, so port 0 wins the first tie after reset.
- **Error flag** is set when `addr >= mem_size`, or when `we` is 1 and `addr < rom_size`.
- **ACCESS**
  - The owner's `gnt` is high this cycle.
  - `mem_addr` and `mem_wr_data` are driven from the latched command.
  - If there is no error: write drives `mem_wr_enable = 1`; read drives `mem_rd_enable = 1` and registers `mem_rd_data` at the end of the cycle.
  - If there is an error: both enables stay 0.
  - Always goes to RESP.
- **RESP**
  - The owner's `rvalid` is high.
  - `rdata` = registered read data (read, no error), otherwise 0.
  - `err` = latched error flag.
  - The non-owner's `rvalid`, `err` and `rdata` are 0.
  - Goes to IDLE.
- **Outputs outside their state**
  - `mem_wr_enable` and `mem_rd_enable` are 0 outside ACCESS.
  - `mem_addr` and `mem_wr_data` hold their last value; their value is don't-care outside ACCESS.
- Requests arriving during ACCESS or RESP wait; they are evaluated in the next IDLE.
- Address compares are 32-bit unsigned. There is no truncation or wrap: address `0x100` with `mem_size = 256` is an error, not word 0.

## Timing
- **Request to grant:** `req` sampled high in IDLE at edge N. `gnt` is high during cycle N+1 (ACCESS). `rvalid` is high during cycle N+2 (RESP).
- **Throughput:** one access per 3 cycles. The next IDLE arbitration is in cycle N+3, so the earliest next `gnt` is in cycle N+4.
- **Write commit:** a write lands in memory at the rising edge that ends ACCESS.
- **Read capture:** read data is captured at that same edge.
- **Reset values:** all outputs are 0 (`gnt`, `rvalid`, `err`, `rdata`, `mem_*` enables, `mem_addr`, `mem_wr_data`).
- **Reset mid-operation:**
  - `rst` high in any state forces IDLE on the next edge.
  - A write whose ACCESS cycle coincides with `rst` high is suppressed; the enable is gated by `!rst`.
  - A response pending from an interrupted access is dropped; no `rvalid` is issued for it.
- **Both ports requesting on every IDLE:** grants alternate strictly 0,1,0,1…

## Test plan
- **Single read:** memory word 5 preloaded with `0xDEAD`; p0 reads addr 5. Expect `p0_gnt` in cycle +1, `mem_rd_enable = 1` that cycle, then `p0_rvalid = 1`, `p0_rdata = 0xDEAD`, `p0_err = 0` in cycle +2.
- **Write then read-back:** p1 writes `0x1234` to addr 10 → `mem_wr_enable` for exactly one cycle with `mem_addr = 10`. A following p1 read of addr 10 returns `0x1234`.
- **Contention:** both ports request continuously for 6 accesses after reset → grant order 0,1,0,1,0,1; each `rvalid` appears only on the owning port.
- **ROM protection:** p0 writes `0xFF` to addr 1 → no `mem_wr_enable`, and `p0_rvalid = 1` with `p0_err = 1`. A read of addr 1 succeeds with `err = 0` and the original contents.
- **Out of range:** p1 reads addr 256 → no `mem_rd_enable`; `p1_err = 1`, `p1_rdata = 0`. Address `0xFFFFFFFF` gives the same result.
- **Reset mid-access:** assert `rst` during the ACCESS cycle of a p0 write to addr 20 → memory word 20 is unchanged, no `p0_rvalid`, all outputs 0, and the block is back in IDLE. The first tie after reset is won by p0.
